// File: rtl/jms_skid_pkg.sv
// Shared types for the jms_skid_buffer two-entry skid buffer.
// Optional parity storage is enabled with JMS_SKID_PARITY_EN.
package jms_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } jms_skid_state_t;

  localparam int JMS_SKID_DEPTH = 2;

endpackage

// File: rtl/jms_skid_entry.sv
// One storage slot of the skid buffer: data register plus optional parity bit.
// The parity bit exists only when JMS_SKID_PARITY_EN is defined.
module jms_skid_entry
  import jms_skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
`ifdef JMS_SKID_PARITY_EN
  input  logic             par_i,
  output logic             par_o,
`endif
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

`ifdef JMS_SKID_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (load_i) begin
      par_q <= par_i;
    end
  end

  assign par_o = par_q;
`endif

endmodule

// File: rtl/jms_skid_buffer.sv
// Two-entry skid buffer (main + skid) breaking the in_ready timing path.
// Define JMS_SKID_PARITY_EN to add per-entry even parity and the parity_err output.
module jms_skid_buffer
  import jms_skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef JMS_SKID_PARITY_EN
  output logic             parity_err,
`endif
  output logic [WIDTH-1:0] out_data
);

  // Handshake: a word moves on a side only in a cycle where valid && ready
  // at posedge clk; valid never waits on ready, and in_ready depends only on
  // the registered state so out_ready has no combinational path to in_ready.

  jms_skid_state_t  state_q;
  logic             in_fire;
  logic             out_fire;
  logic             main_load;
  logic             skid_load;
  logic [WIDTH-1:0] main_din;
  wire  [WIDTH-1:0] main_data;
  wire  [WIDTH-1:0] skid_data;

  assign in_ready  = (state_q == EMPTY) || (state_q == BUSY);
  assign out_valid = (state_q == BUSY) || (state_q == FULL);
  assign out_data  = main_data;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // In FULL the main slot refills from skid; otherwise it captures in_data.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_din  = in_data;
    case (state_q)
      EMPTY: main_load = in_fire;
      BUSY: begin
        main_load = in_fire && out_fire;
        skid_load = in_fire && !out_fire;
      end
      FULL: begin
        main_load = out_fire;
        main_din  = skid_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_q <= BUSY;
        BUSY: begin
          if (in_fire && !out_fire) begin
            state_q <= FULL;
          end else if (!in_fire && out_fire) begin
            state_q <= EMPTY;
          end
        end
        FULL: if (out_fire) state_q <= BUSY;
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef JMS_SKID_PARITY_EN
  logic main_par;
  logic skid_par;
  logic main_par_din;

  assign main_par_din = (state_q == FULL) ? skid_par : ^in_data;
  assign parity_err   = out_valid && ((^main_data) != main_par);

  jms_skid_entry #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (main_load),
    .data_i (main_din),
    .par_i  (main_par_din),
    .par_o  (main_par),
    .data_o (main_data)
  );

  jms_skid_entry #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .data_i (in_data),
    .par_i  (^in_data),
    .par_o  (skid_par),
    .data_o (skid_data)
  );
`else
  jms_skid_entry #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (main_load),
    .data_i (main_din),
    .data_o (main_data)
  );

  jms_skid_entry #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .data_i (in_data),
    .data_o (skid_data)
  );
`endif

endmodule

// File: tb/tb_jms_skid_buffer.sv
// Self-checking bench for jms_skid_buffer: a word-queue reference model
// tracks accepted words; JMS_SKID_PARITY_EN adds the parity-error scenario.
module tb_jms_skid_buffer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef JMS_SKID_PARITY_EN
  logic         parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Words accepted but not yet consumed, oldest first; at most two fit.
  logic [W-1:0] exp_q[$];
  logic         last_stall = 1'b0;
  logic [W-1:0] last_data = '0;

  jms_skid_buffer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef JMS_SKID_PARITY_EN
    .parity_err (parity_err),
`endif
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("out_data", 64'(out_data), 64'(exp_q[0]));
    if (last_stall) check("stall_hold", 64'(out_data), 64'(last_data));
`ifdef JMS_SKID_PARITY_EN
    check("parity_err", 64'(parity_err), 64'(0));
`endif
  endtask

  // Called at a negedge: check current outputs, drive the next inputs and
  // advance the model to what the next posedge should produce.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy);
    logic acc;
    logic pop;
    check_model();
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    acc = iv && (exp_q.size() < 2);
    pop = ordy && (exp_q.size() > 0);
    last_stall = (exp_q.size() > 0) && !ordy;
    if (exp_q.size() > 0) last_data = exp_q[0];
    if (pop) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(id);
    @(negedge clk);
  endtask

  initial begin
    // Reset asserted from time zero.
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_data", 64'(out_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      check("idle_out_data", 64'(out_data), 64'(0));
      step(1'b0, '0, 1'b0);
    end

    // Streaming at full rate.
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    // Fill both entries, offer a third word while full, then drain.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_out_data", 64'(out_data), 64'(8'hA5));
    step(1'b1, 8'hFF, 1'b0);
    check("full_hold_data", 64'(out_data), 64'(8'hA5));
    step(1'b1, 8'hFF, 1'b1);
    check("drain_second", 64'(out_data), 64'(8'h5A));
    step(1'b1, 8'hFF, 1'b1);
    check("late_word", 64'(out_data), 64'(8'hFF));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Asynchronous reset while full, away from any clock edge.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    check("arst_out_data", 64'(out_data), 64'(0));
    exp_q.delete();
    last_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h33, 1'b1);
    check("post_rst_first", 64'(out_data), 64'(8'h33));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    check("drained", 64'(exp_q.size()), 64'(0));
    check("final_out_valid", 64'(out_valid), 64'(0));

`ifdef JMS_SKID_PARITY_EN
    step(1'b1, 8'h03, 1'b0);
    check("par_clean", 64'(parity_err), 64'(0));
    force dut.main_data = 8'h02;
    #1;
    check("par_err_forced", 64'(parity_err), 64'(1));
    release dut.main_data;
    #1;
    check("par_err_released", 64'(parity_err), 64'(0));
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
